fetch_issue: RTL and testbench

- Instruction-fetch producer that drives the IF side of the IF/ID pipeline register: Instr1, Instr_PC, Instr_PC_Plus4, Branch_prediction and Branch_predictions.
- Owns the PC and a variable-latency req/ready instruction-memory handshake.
- Holds a 2-bit saturating-counter branch history table (BHT) for conditional-branch prediction.
- Accepts redirects and BHT training from the resolving stage.

---
 rtl/fetch_issue_pkg.sv | 23 ++
 rtl/bht_2bit.sv | 39 +++
 rtl/fetch_issue.sv | 147 ++++++++++++++
 tb/tb_fetch_issue.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_issue_pkg.sv
// Shared constants for the fetch/issue stage: branch opcodes, FSM encoding
// and the branch-history counter reset value.
package fetch_issue_pkg;

  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_BNE  = 6'd5;
  localparam logic [5:0] OP_BLEZ = 6'd6;
  localparam logic [5:0] OP_BGTZ = 6'd7;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [1:0] BHT_INIT = 2'b01;

  function automatic logic is_cond_br(input logic [5:0] opcode);
    return (opcode == OP_BEQ) || (opcode == OP_BNE) ||
           (opcode == OP_BLEZ) || (opcode == OP_BGTZ);
  endfunction

endpackage

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters: combinational lookup,
// clocked training, all entries return to weakly-not-taken on reset.
module bht_2bit
  import fetch_issue_pkg::*;
#(
  parameter int BHT_BITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BHT_BITS-1:0] rd_idx,
  output logic [1:0]          rd_ctr,
  input  logic                wr_en,
  input  logic [BHT_BITS-1:0] wr_idx,
  input  logic                wr_taken
);

  localparam int ENTRIES = 1 << BHT_BITS;

  logic [1:0] ctr_q [ENTRIES];

  function automatic logic [1:0] sat_step(input logic [1:0] ctr, input logic taken);
    if (taken)
      return (ctr == 2'b11) ? ctr : ctr + 2'd1;
    else
      return (ctr == 2'b00) ? ctr : ctr - 2'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= BHT_INIT;
    end else if (wr_en) begin
      ctr_q[wr_idx] <= sat_step(ctr_q[wr_idx], wr_taken);
    end
  end

  // Read sees the pre-update value when it collides with a write.
  assign rd_ctr = ctr_q[rd_idx];

endmodule

// File: rtl/fetch_issue.sv
// Instruction fetch stage: owns the PC, runs the req/ready imem handshake,
// predicts conditional branches from the BHT and feeds the IF/ID register.
module fetch_issue
  import fetch_issue_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int          BHT_BITS = 6
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  output logic [31:0] Imem_addr_OUT,
  output logic        Imem_req_OUT,
  input  logic        Imem_ready_IN,
  input  logic [31:0] Imem_data_IN,
  input  logic        Redirect_valid_IN,
  input  logic [31:0] Redirect_PC_IN,
  input  logic        Update_valid_IN,
  input  logic [31:0] Update_PC_IN,
  input  logic        Update_taken_IN,
  output logic        Instr_valid_OUT,
  output logic [31:0] Instr1_OUT,
  output logic [31:0] Instr_PC_OUT,
  output logic [31:0] Instr_PC_Plus4_OUT,
  output logic        Branch_prediction_OUT,
  output logic [1:0]  Branch_predictions_OUT
);

  state_t      state;
  logic [31:0] pc;
  logic [31:0] addr_q;
  logic [31:0] hold_word;
  logic        hold_pred;
  logic [1:0]  hold_ctr;

  logic [1:0]  ctr;
  logic [31:0] cur_word;
  logic        cur_pred;
  logic [1:0]  cur_ctr;
  logic [31:0] next_pc;
  logic        fetch_hit;
  logic        present;

  function automatic logic [31:0] branch_target(input logic [31:0] base, input logic [15:0] imm);
    logic signed [31:0] offset;
    offset = {{14{imm[15]}}, imm, 2'b00};
    return base + 32'd4 + offset;
  endfunction

  bht_2bit #(.BHT_BITS(BHT_BITS)) u_bht (
    .clk      (CLK),
    .rst      (RESET),
    .rd_idx   (pc[BHT_BITS+1:2]),
    .rd_ctr   (ctr),
    .wr_en    (Update_valid_IN),
    .wr_idx   (Update_PC_IN[BHT_BITS+1:2]),
    .wr_taken (Update_taken_IN)
  );

  logic unused_upd_bits;
  assign unused_upd_bits = &{1'b0, Update_PC_IN[31:BHT_BITS+2], Update_PC_IN[1:0]};

  assign fetch_hit = (state == FETCH) && Imem_ready_IN;

  // In HOLD the PC register is frozen, so it still names the held word.
  always_comb begin
    cur_word = hold_word;
    cur_pred = hold_pred;
    cur_ctr  = hold_ctr;
    if (state != HOLD) begin
      cur_word = Imem_data_IN;
      cur_ctr  = ctr;
      cur_pred = is_cond_br(Imem_data_IN[31:26]) & ctr[1];
    end
  end

  assign next_pc = cur_pred ? branch_target(pc, cur_word[15:0]) : pc + 32'd4;
  assign present = !RESET && !Redirect_valid_IN && (fetch_hit || (state == HOLD));

  assign Imem_req_OUT           = !RESET && (state != HOLD);
  assign Imem_addr_OUT          = addr_q;
  assign Instr_valid_OUT        = present;
  assign Instr1_OUT             = present ? cur_word : '0;
  assign Instr_PC_OUT           = present ? pc : '0;
  assign Instr_PC_Plus4_OUT     = present ? pc + 32'd4 : '0;
  assign Branch_prediction_OUT  = present & cur_pred;
  assign Branch_predictions_OUT = present ? cur_ctr : 2'b00;

  // Hold buffer: pure data, only meaningful while state is HOLD.
  always_ff @(posedge CLK) begin
    if (fetch_hit) begin
      hold_word <= Imem_data_IN;
      hold_pred <= cur_pred;
      hold_ctr  <= ctr;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      addr_q <= RESET_PC;
    end else if (Redirect_valid_IN) begin
      pc <= Redirect_PC_IN;
      case (state)
        FETCH: begin
          // An issued request cannot change address; drain it first.
          if (Imem_ready_IN) addr_q <= Redirect_PC_IN;
          else               state  <= DRAIN;
        end
        HOLD: begin
          state  <= FETCH;
          addr_q <= Redirect_PC_IN;
        end
        default: ;
      endcase
    end else begin
      case (state)
        FETCH: begin
          if (Imem_ready_IN) begin
            if (STALL) begin
              state <= HOLD;
            end else begin
              pc     <= next_pc;
              addr_q <= next_pc;
            end
          end
        end
        HOLD: begin
          if (!STALL) begin
            state  <= FETCH;
            pc     <= next_pc;
            addr_q <= next_pc;
          end
        end
        DRAIN: begin
          if (Imem_ready_IN) begin
            state  <= FETCH;
            addr_q <= pc;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_issue.sv
// Randomized bench for fetch_issue against a per-cycle behavioural model of
// the fetch stream, plus directed scenarios for prediction, stall, redirect and reset.
module tb_fetch_issue;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        STALL;
  logic [31:0] Imem_addr_OUT;
  logic        Imem_req_OUT;
  logic        Imem_ready_IN;
  logic [31:0] Imem_data_IN;
  logic        Redirect_valid_IN;
  logic [31:0] Redirect_PC_IN;
  logic        Update_valid_IN;
  logic [31:0] Update_PC_IN;
  logic        Update_taken_IN;
  logic        Instr_valid_OUT;
  logic [31:0] Instr1_OUT;
  logic [31:0] Instr_PC_OUT;
  logic [31:0] Instr_PC_Plus4_OUT;
  logic        Branch_prediction_OUT;
  logic [1:0]  Branch_predictions_OUT;

  always #5 CLK = ~CLK;

  fetch_issue #(.RESET_PC(RESET_PC), .BHT_BITS(6)) dut (
    .CLK                    (CLK),
    .RESET                  (RESET),
    .STALL                  (STALL),
    .Imem_addr_OUT          (Imem_addr_OUT),
    .Imem_req_OUT           (Imem_req_OUT),
    .Imem_ready_IN          (Imem_ready_IN),
    .Imem_data_IN           (Imem_data_IN),
    .Redirect_valid_IN      (Redirect_valid_IN),
    .Redirect_PC_IN         (Redirect_PC_IN),
    .Update_valid_IN        (Update_valid_IN),
    .Update_PC_IN           (Update_PC_IN),
    .Update_taken_IN        (Update_taken_IN),
    .Instr_valid_OUT        (Instr_valid_OUT),
    .Instr1_OUT             (Instr1_OUT),
    .Instr_PC_OUT           (Instr_PC_OUT),
    .Instr_PC_Plus4_OUT     (Instr_PC_Plus4_OUT),
    .Branch_prediction_OUT  (Branch_prediction_OUT),
    .Branch_predictions_OUT (Branch_predictions_OUT)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [64];

  // stimulus for the next cycle
  logic        s_stall, s_redir, s_upd, s_utaken;
  logic [31:0] s_rpc, s_upc;
  int          ready_pct;

  // reference model
  logic [31:0] m_pc, m_addr;
  bit          m_held, m_drain;
  logic [31:0] h_word, h_pc;
  bit          h_pred;
  int          h_ctr;
  int          bht [64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int bidx(input logic [31:0] a);
    return int'(a[7:2]);
  endfunction

  function automatic logic [31:0] taken_target(input logic [31:0] pc, input logic [31:0] word);
    int imm;
    imm = int'(word[15:0]);
    if (imm > 32767) imm -= 65536;
    return pc + 32'd4 + 32'(imm * 4);
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC; m_addr = RESET_PC;
    m_held = 0; m_drain = 0;
    for (int i = 0; i < 64; i++) bht[i] = 1;
  endtask

  task automatic quiet_stim();
    s_stall = 0; s_redir = 0; s_upd = 0; s_utaken = 0;
    s_rpc = '0; s_upc = '0;
  endtask

  task automatic zero_inputs();
    STALL = 0; Imem_ready_IN = 0; Imem_data_IN = '0;
    Redirect_valid_IN = 0; Redirect_PC_IN = '0;
    Update_valid_IN = 0; Update_PC_IN = '0; Update_taken_IN = 0;
  endtask

  // One clock: drive after the edge, compare at the falling edge, advance the model.
  task automatic step();
    bit          have, pr, rdy;
    logic [31:0] w, p, nxt, rd_word;
    int          c, op;
    @(posedge CLK); #1;
    STALL = s_stall;
    Redirect_valid_IN = s_redir; Redirect_PC_IN = s_rpc;
    Update_valid_IN = s_upd; Update_PC_IN = s_upc; Update_taken_IN = s_utaken;
    rdy = Imem_req_OUT && (int'($urandom_range(0, 99)) < ready_pct);
    rd_word = rdy ? mem[Imem_addr_OUT[7:2]] : $urandom;
    Imem_ready_IN = rdy; Imem_data_IN = rd_word;
    @(negedge CLK);

    chk("req", {31'b0, Imem_req_OUT}, {31'b0, !m_held});
    if (!m_held) chk("addr", Imem_addr_OUT, m_addr);

    have = 0; pr = 0; w = '0; p = '0; c = 0;
    if (!s_redir) begin
      if (m_held) begin
        have = 1; w = h_word; p = h_pc; pr = h_pred; c = h_ctr;
      end else if (!m_drain && rdy) begin
        have = 1; w = rd_word; p = m_pc; c = bht[bidx(m_pc)];
        op = int'(w[31:26]);
        pr = (op >= 4 && op <= 7) && (c >= 2);
      end
    end
    chk("valid", {31'b0, Instr_valid_OUT}, {31'b0, have});
    chk("instr", Instr1_OUT, have ? w : 32'h0);
    chk("pc", Instr_PC_OUT, have ? p : 32'h0);
    chk("pc_plus4", Instr_PC_Plus4_OUT, have ? p + 32'd4 : 32'h0);
    chk("pred", {31'b0, Branch_prediction_OUT}, {31'b0, have & pr});
    chk("ctr", {30'b0, Branch_predictions_OUT}, have ? 32'(c) : 32'h0);

    if (m_held) nxt = h_pred ? taken_target(h_pc, h_word) : h_pc + 32'd4;
    else        nxt = pr ? taken_target(m_pc, rd_word) : m_pc + 32'd4;

    if (s_upd) begin
      if (s_utaken && bht[bidx(s_upc)] < 3) bht[bidx(s_upc)]++;
      else if (!s_utaken && bht[bidx(s_upc)] > 0) bht[bidx(s_upc)]--;
    end

    if (s_redir) begin
      if (m_held) begin m_held = 0; m_addr = s_rpc; end
      else if (!m_drain) begin
        if (rdy) m_addr = s_rpc;
        else     m_drain = 1;
      end
      m_pc = s_rpc;
    end else if (m_held) begin
      if (!s_stall) begin m_held = 0; m_pc = nxt; m_addr = nxt; end
    end else if (m_drain) begin
      if (rdy) begin m_drain = 0; m_addr = m_pc; end
    end else if (rdy) begin
      if (!s_stall) begin
        m_pc = nxt; m_addr = nxt;
      end else begin
        m_held = 1; h_word = rd_word; h_pc = m_pc; h_pred = pr; h_ctr = c;
      end
    end
  endtask

  task automatic do_reset();
    RESET = 1; zero_inputs(); quiet_stim();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_valid", {31'b0, Instr_valid_OUT}, 32'h0);
    chk("rst_req", {31'b0, Imem_req_OUT}, 32'h0);
    RESET = 0;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1; zero_inputs(); quiet_stim();
    ready_pct = 100;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4] = 32'h1000_FFFF;

    // Sequential fetch from reset, untrained beq falls through.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step();
      if (i < 3) begin
        chk("seq_pc", Instr_PC_OUT, RESET_PC + 32'(4 * i));
        chk("seq_ctr", {30'b0, Branch_predictions_OUT}, 32'h1);
      end
      if (i == 4) chk("untrained_pred", {31'b0, Branch_prediction_OUT}, 32'h0);
      if (i == 5) chk("untrained_next", Instr_PC_OUT, 32'h0040_0014);
    end

    // Trained beq at 0x00400010 loops onto itself.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      s_upd = (i < 2); s_upc = 32'h0040_0010; s_utaken = 1;
      step();
      if (i == 4) begin
        chk("trained_pred", {31'b0, Branch_prediction_OUT}, 32'h1);
        chk("trained_ctr", {30'b0, Branch_predictions_OUT}, 32'h3);
      end
      if (i == 5) chk("trained_next", Instr_PC_OUT, 32'h0040_0010);
    end
    quiet_stim();

    // Stall while a word is delivered, then release.
    do_reset();
    step();
    s_stall = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_valid", {31'b0, Instr_valid_OUT}, 32'h1);
      chk("stall_pc", Instr_PC_OUT, 32'h0040_0004);
    end
    s_stall = 0;
    step();
    step();
    chk("after_stall_pc", Instr_PC_OUT, 32'h0040_0008);

    // Redirect while a slow request is outstanding.
    do_reset();
    ready_pct = 0;
    step();
    s_redir = 1; s_rpc = 32'h0040_0100;
    step();
    s_redir = 0;
    step();
    chk("drain_addr", Imem_addr_OUT, RESET_PC);
    ready_pct = 100;
    step();
    chk("drain_discard", {31'b0, Instr_valid_OUT}, 32'h0);
    step();
    chk("redirect_addr", Imem_addr_OUT, 32'h0040_0100);

    // Counter saturation and same-cycle read-before-update.
    do_reset();
    ready_pct = 0;
    s_upd = 1; s_upc = RESET_PC; s_utaken = 1;
    repeat (4) step();
    s_upd = 0; ready_pct = 100;
    step();
    chk("sat_hi", {30'b0, Branch_predictions_OUT}, 32'h3);
    ready_pct = 0;
    s_redir = 1; s_rpc = RESET_PC; s_upd = 1; s_utaken = 0;
    step();
    s_redir = 0;
    repeat (4) step();
    s_upd = 0; ready_pct = 100;
    step();
    s_upd = 1; s_utaken = 1;
    step();
    chk("sat_lo_old", {30'b0, Branch_predictions_OUT}, 32'h0);
    quiet_stim();

    // Randomized traffic over a branch-rich memory image.
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 1) == 0)
        mem[i] = {6'(4 + $urandom_range(0, 3)), 10'($urandom), 16'($urandom_range(0, 16) - 8)};
      else
        mem[i] = {6'(8 + $urandom_range(0, 50)), 26'($urandom)};
    end
    ready_pct = 40;
    for (int i = 0; i < 2500; i++) begin
      s_stall  = ($urandom_range(0, 99) < 30);
      s_redir  = ($urandom_range(0, 99) < 8);
      s_rpc    = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : RESET_PC + 32'($urandom_range(0, 63) * 4);
      s_upd    = ($urandom_range(0, 99) < 40);
      s_upc    = RESET_PC + 32'($urandom_range(0, 63) * 4);
      s_utaken = ($urandom_range(0, 99) < 60);
      step();
    end

    // Reset asserted while holding a stalled instruction.
    quiet_stim();
    s_stall = 1; ready_pct = 100;
    for (int i = 0; i < 20 && !m_held; i++) step();
    chk("hold_reached", {31'b0, m_held}, 32'h1);
    step();
    #2 RESET = 1;
    #1;
    chk("mid_rst_valid", {31'b0, Instr_valid_OUT}, 32'h0);
    chk("mid_rst_instr", Instr1_OUT, 32'h0);
    chk("mid_rst_req", {31'b0, Imem_req_OUT}, 32'h0);
    chk("mid_rst_ctr", {30'b0, Branch_predictions_OUT}, 32'h0);
    zero_inputs(); quiet_stim();
    @(posedge CLK);
    @(negedge CLK);
    RESET = 0;
    model_reset();
    step();
    chk("post_rst_addr", Imem_addr_OUT, RESET_PC);
    ready_pct = 50;
    for (int i = 0; i < 300; i++) begin
      s_stall = ($urandom_range(0, 99) < 20);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
